// File: rtl/hilo_mdu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : hilo_mdu_ctrl                                                      |
// | Purpose  : HI/LO multiply/divide sequencer (iterative shift-add / restoring)  |
// | Options  : MDU_FAST_MUL_EN - single-cycle MULT/MULTU                         |
// | Revision : 1.0                                                                |
// +-----------------------------------------------------------------------------+
module hilo_mdu_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] hi_cur,
  input  logic [WIDTH-1:0] lo_cur,
  input  logic             flush,
  output logic             stall,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata,
  output logic             busy
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(ITERS - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               is_div_q, neg_q_q, neg_r_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic op_mul, op_div, op_sgn, op_mt, div_zero, accept, iter_op, stall_op;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign op_mul   = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div   = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_sgn   = (op == OP_MULT) || (op == OP_DIV);
  assign op_mt    = (op == OP_MTHI) || (op == OP_MTLO);
  assign div_zero = op_div && (src_b == '0);
  assign accept   = start && (op_mul || op_div || op_mt) && !flush && !rst
                    && (state_q != S_BUSY);
  assign a_abs    = (op_sgn && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_abs    = (op_sgn && src_b[WIDTH-1]) ? -src_b : src_b;

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = op_sgn ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
  assign ext_b     = op_sgn ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
  assign fast_prod = ext_a * ext_b;
  assign iter_op   = op_div && !div_zero;
  assign stall_op  = op_div;
`else
  assign iter_op   = (op_mul || op_div) && !div_zero;
  assign stall_op  = op_mul || op_div;
`endif

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] step, prod;
  logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_ok   = !div_diff[WIDTH];
  assign step     = is_div_q
                    ? {(div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ok}
                    : {mul_sum, acc_q[WIDTH-1:1]};
  assign prod     = neg_q_q ? -step : step;
  assign quo      = neg_q_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
  assign rem      = neg_r_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
  assign fin_hi   = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
  assign fin_lo   = is_div_q ? quo : prod[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    hilo_we = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) hilo_we = !flush;
        if (accept) begin
          state_d = iter_op ? S_BUSY : S_DONE;
          stall   = stall_op;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          if (count_q == C_LAST) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (accept) begin
      count_q  <= '0;
      is_div_q <= op_div;
      neg_q_q  <= op_sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      neg_r_q  <= op_sgn && src_a[WIDTH-1];
      opnd_q   <= op_div ? b_abs : a_abs;
      acc_q    <= {{WIDTH{1'b0}}, (op_div ? a_abs : b_abs)};
      if (op == OP_MTHI) begin
        hi_q <= src_a;
        lo_q <= lo_cur;
      end else if (op == OP_MTLO) begin
        hi_q <= hi_cur;
        lo_q <= src_a;
      end else if (div_zero) begin
        hi_q <= src_a;
        lo_q <= '1;
      end
`ifdef MDU_FAST_MUL_EN
      else if (op_mul) begin
        hi_q <= fast_prod[2*WIDTH-1:WIDTH];
        lo_q <= fast_prod[WIDTH-1:0];
      end
`endif
    end else if (state_q == S_BUSY && !flush) begin
      acc_q   <= step;
      count_q <= count_q + 1'b1;
      if (count_q == C_LAST) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end
    end
  end

  assign busy     = (state_q == S_BUSY);
  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_mdu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_hilo_mdu_ctrl                                                   |
// | Purpose  : Randomised + directed self-checking bench for hilo_mdu_ctrl        |
// | Revision : 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_hilo_mdu_ctrl;
  localparam int W = 32;
  localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  src_a = '0, src_b = '0, hi_cur, lo_cur;
  logic          stall, hilo_we, busy;
  logic [W-1:0]  hi_wdata, lo_wdata;

  always #5 clk = ~clk;

  hilo_mdu_ctrl #(.WIDTH(W), .ITERS(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_cur(hi_cur), .lo_cur(lo_cur), .flush(flush), .stall(stall),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .busy(busy)
  );

  int errors = 0, checks = 0;

  // Model: 0 idle, 1 busy (m_cnt cycles left), 2 done; plus the HILO register itself
  int           m_st = 0, m_cnt = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0, hilo_hi = '0, hilo_lo = '0;
  assign hi_cur = hilo_hi;
  assign lo_cur = hilo_lo;

  int           cyc, n_stall, n_we, we_cyc;
  logic [W-1:0] got_hi, got_lo;

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a, b, hc, lc);
    longint sa, sb, q, r;
    logic [63:0] p;
    case (o)
      MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      MULTU: return {32'b0, a} * {32'b0, b};
      DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
      end
      DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      MTHI: return {a, lc};
      MTLO: return {hc, a};
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare at negedge, advance model after the edge
  task automatic cycle(input bit st, input logic [2:0] o, input logic [31:0] a, b, input bit fl);
    bit acc, is_mul, is_div, stall_acc, it, e_we, e_stall;
    logic [63:0] r;
    start = st; op = o; src_a = a; src_b = b; flush = fl;
    @(negedge clk);
    is_mul    = (o == MULT) || (o == MULTU);
    is_div    = (o == DIV) || (o == DIVU);
    acc       = st && (o >= 3'd1) && (o <= 3'd6) && !fl && (m_st != 1);
    stall_acc = (is_mul && !FAST) || is_div;
    it        = stall_acc && !(is_div && b == 0);
    e_we      = (m_st == 2) && !fl;
    e_stall   = ((m_st == 1) && !fl) || (acc && stall_acc);
    r         = ref_op(o, a, b, hilo_hi, hilo_lo);
    chk("stall", stall, e_stall);
    chk("hilo_we", hilo_we, e_we);
    chk("busy", busy, m_st == 1);
    chk("hi_wdata", hi_wdata, m_hi);
    chk("lo_wdata", lo_wdata, m_lo);
    if (stall) n_stall++;
    if (hilo_we) begin
      n_we++; we_cyc = cyc; got_hi = hi_wdata; got_lo = lo_wdata;
    end
    @(posedge clk);
    #1;
    if (e_we) begin hilo_hi = m_hi; hilo_lo = m_lo; end
    if (m_st == 1) begin
      if (fl) m_st = 0;
      else begin
        m_cnt--;
        if (m_cnt == 0) begin m_st = 2; m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (acc) begin
      if (it) begin m_st = 1; m_cnt = W; {p_hi, p_lo} = r; end
      else    begin m_st = 2; {m_hi, m_lo} = r; end
    end else begin
      m_st = 0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, NONE, '0, '0, 1'b0);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, b, input int n_idle);
    n_stall = 0; n_we = 0; we_cyc = -1; cyc = 0;
    cycle(1'b1, o, a, b, 1'b0);
    idle(n_idle);
  endtask

  task automatic do_reset();
    start = 0; op = NONE; flush = 0; rst = 1'b1;
    #2;
    chk("rst_stall", stall, 1'b0);
    chk("rst_we", hilo_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi", hi_wdata, '0);
    chk("rst_lo", lo_wdata, '0);
    m_st = 0; m_hi = '0; m_lo = '0; hilo_hi = '0; hilo_lo = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Hand-computed pins on the reference model
    chk("model_mult",  ref_op(MULT,  32'hFFFF_FFFD, 32'd5, '0, '0), 64'hFFFF_FFFF_FFFF_FFF1);
    chk("model_multu", ref_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0), 64'hFFFF_FFFE_0000_0001);
    chk("model_div",   ref_op(DIV,   32'hFFFF_FFF9, 32'd2, '0, '0), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_divov", ref_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, '0, '0), 64'h0000_0000_8000_0000);

    do_reset();

    run(MULT, 32'hFFFF_FFFD, 32'd5, 35);
    chk("mult_we_cycle", we_cyc, FAST ? 1 : 33);
    chk("mult_stall_cycles", n_stall, FAST ? 0 : 33);
    chk("mult_we_count", n_we, 1);
    chk("mult_hi", got_hi, 32'hFFFF_FFFF);
    chk("mult_lo", got_lo, 32'hFFFF_FFF1);

    run(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
    chk("multu_hi", got_hi, 32'hFFFF_FFFE);
    chk("multu_lo", got_lo, 32'h0000_0001);

    run(DIV, 32'hFFFF_FFF9, 32'd2, 35);
    chk("div_we_cycle", we_cyc, 33);
    chk("div_hi", got_hi, 32'hFFFF_FFFF);
    chk("div_lo", got_lo, 32'hFFFF_FFFD);

    run(DIVU, 32'd100, 32'd7, 35);
    chk("divu_hi", got_hi, 32'd2);
    chk("divu_lo", got_lo, 32'd14);

    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 35);
    chk("divov_hi", got_hi, 32'h0);
    chk("divov_lo", got_lo, 32'h8000_0000);

    run(DIVU, 32'h1234, 32'd0, 3);
    chk("div0_we_cycle", we_cyc, 1);
    chk("div0_stall_cycles", n_stall, 1);
    chk("div0_hi", got_hi, 32'h1234);
    chk("div0_lo", got_lo, 32'hFFFF_FFFF);

    run(MTLO, 32'h11, 32'd0, 2);
    run(MTHI, 32'hA5A5_A5A5, 32'd0, 2);
    chk("mthi_we_cycle", we_cyc, 1);
    chk("mthi_stall_cycles", n_stall, 0);
    chk("mthi_hi", got_hi, 32'hA5A5_A5A5);
    chk("mthi_lo", got_lo, 32'h11);

    // MULT flushed at cycle 10, next op accepted at cycle 11
    n_we = 0; cyc = 0;
    cycle(1'b1, MULT, 32'd7, 32'd9, 1'b0);
    idle(9);
    cycle(1'b0, NONE, '0, '0, 1'b1);
    cycle(1'b1, DIVU, 32'd50, 32'd5, 1'b0);
    chk("flush_no_we", n_we, FAST ? 1 : 0);
    idle(35);

    // Flush in DONE, flush+start together, back-to-back accepts in DONE, op 7
    cycle(1'b1, MTHI, 32'hDEAD_BEEF, '0, 1'b0);
    cycle(1'b0, NONE, '0, '0, 1'b1);
    cycle(1'b1, DIVU, 32'd5, 32'd1, 1'b1);
    cycle(1'b1, MTHI, 32'h1, '0, 1'b0);
    cycle(1'b1, MTLO, 32'h2, '0, 1'b0);
    cycle(1'b1, DIV, 32'hFFFF_FF00, 32'd3, 1'b0);
    idle(34);
    cycle(1'b1, 3'd7, 32'h5, 32'h6, 1'b0);
    idle(2);

    // Reset in the middle of a divide
    cycle(1'b1, DIVU, 32'd1000, 32'd3, 1'b0);
    idle(5);
    do_reset();
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      cycle(1'(($urandom_range(0, 1))), 3'($urandom_range(0, 7)), pick(), pick(),
            $urandom_range(0, 39) == 0);
    end
    idle(36);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
- Multiply/divide sequencer that owns all writes into the HI/LO register pair of the CPU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs an iterative 32-step shift-add multiply or restoring divide.
- Stalls the pipeline while busy, then issues a single write pulse with HI/LO data to the HILO register.
- Write data and enable are also exported for forwarding.

Parameters:
- WIDTH, 32, operand and HI/LO half width.
- ITERS, 32, iterations per mul/div; must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  op request from EX, valid when op != NONE.
- op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 treated as NONE.
- src_a  in  WIDTH  rs value: multiplicand, dividend, or MT* data.
- src_b  in  WIDTH  rt value: multiplier or divisor.
- hi_cur  in  WIDTH  current HI from the HILO register.
- lo_cur  in  WIDTH  current LO from the HILO register.
- flush  in  1  exception/flush: cancels any in-flight op.
- stall  out  1  hold IF..EX.
- hilo_we  out  1  one-cycle write strobe to HILO.
- hi_wdata  out  WIDTH  HI write data.
- lo_wdata  out  WIDTH  LO write data.
- busy  out  1  state == BUSY.

Behaviour:
- States: IDLE, BUSY, DONE. Async reset → IDLE, count=0, result regs=0. All outputs read 0 during and after reset.
- Accept: start && op valid && !flush, in IDLE or DONE. Ops are not accepted in BUSY.
- MULT/MULTU/DIV/DIVU accepted:
  - Latch operands; for signed ops latch absolute values plus the sign flags.
  - count=0, go to BUSY.
  - stall=1 combinationally in the accept cycle and every BUSY cycle.
- BUSY, one iteration per cycle:
  - Multiply: 64-bit shift-add of |a|*|b|.
  - Divide: restoring. Remainder shift-left, subtract divisor, set quotient bit if non-negative.
  - When count==ITERS-1, go to DONE.
- DONE, exactly one cycle:
  - hilo_we=1, stall=0.
  - Multiply: {hi,lo} = product; negated (two's complement, 64-bit) if MULT and the signs differ.
  - Divide: lo = quotient, hi = remainder.
    - DIV: quotient negated if the signs differ.
    - DIV: remainder takes the sign of the dividend.
  - HILO updates on the edge ending DONE.
  - Latency: accept at cycle 0 → DONE at cycle 33; stall high for cycles 0..32.
- MTHI accepted: go to DONE next cycle with hi=src_a, lo=lo_cur sampled at accept. stall=0.
- MTLO accepted: same, with lo=src_a, hi=hi_cur.
- Divide-by-zero (src_b==0, DIV or DIVU):
  - No iterations; go to DONE next cycle. stall=1 in the accept cycle only.
  - lo=0xFFFFFFFF, hi=src_a raw. No sign fix.
- DIV 0x80000000 / -1: quotient=0x80000000, remainder=0. This follows naturally from 32-bit wrap; no special case.
- Outside DONE: hilo_we=0. hi_wdata/lo_wdata hold the last result registers.
- flush:
  - In BUSY: next state IDLE, no write, stall=0 in the flush cycle.
  - In DONE: write suppressed (hilo_we=0).
  - flush && start in the same cycle: flush wins, nothing accepted.
- Accept while in DONE: the current write still completes and the new op starts (DONE→BUSY or DONE→DONE).
- rst asserted mid-BUSY: immediate IDLE, no write, stall=0.

Optional Feature:
- MDU_FAST_MUL_EN defined:
  - MULT/MULTU computed in one cycle with a 64-bit signed/unsigned multiplier.
  - Accept → DONE next cycle, stall=0 (same timing as MT*).
  - DIV/DIVU unchanged.
- Not defined: MULT/MULTU use the 32-cycle iterative path above.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 → single hilo_we at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFF1. stall high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=0x1234, b=0 → write at cycle 1, lo=0xFFFFFFFF, hi=0x1234. stall high for 1 cycle only.
- MTHI src_a=0xA5A5A5A5 with lo_cur=0x11 → next cycle hilo_we=1, hi=0xA5A5A5A5, lo=0x11, stall never high. Then MULT with flush at cycle 10 → no hilo_we, stall low from cycle 10, next start accepted at cycle 11.
